// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect sequencing for the fetch, decode
// and execute registers, plus saturating stall and redirect counters.
module hazard_ctrl #(
    parameter int unsigned AWIDTH           = 32,
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic                 id_uses_rs1_i,
    input  logic                 id_uses_rs2_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 ex_is_load_i,
    input  logic                 ex_br_taken_i,
    input  logic [AWIDTH-1:0]    ex_br_target_i,
    input  logic                 mem_busy_i,
    output logic                 stall_f_o,
    output logic                 stall_d_o,
    output logic                 stall_e_o,
    output logic                 flush_d_o,
    output logic                 flush_e_o,
    output logic                 redirect_o,
    output logic [AWIDTH-1:0]    redirect_pc_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] redir_cnt_o
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;
    localparam logic [1:0] BUBBLES     = 2'(REDIRECT_BUBBLES);

    logic [0:0]           state_q, state_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;
    logic                 luh;

    always_comb begin
        luh = ex_is_load_i && (ex_rd_i != 5'd0) &&
              ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
               (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
    end

    // Priority: rst > mem_busy > redirect bubbles > taken branch > load-use.
    always_comb begin
        stall_f_o  = 1'b0;
        stall_d_o  = 1'b0;
        stall_e_o  = 1'b0;
        flush_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        redirect_o = 1'b0;
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        if (rst) begin
            state_d = ST_RUN;
            bcnt_d  = 2'd0;
        end else if (mem_busy_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
        end else if (state_q == ST_REDIRECT) begin
            flush_d_o = 1'b1;
            bcnt_d    = bcnt_q - 2'd1;
            if (bcnt_q == 2'd1) begin
                state_d = ST_RUN;
            end
        end else if (ex_br_taken_i) begin
            redirect_o = 1'b1;
            flush_d_o  = 1'b1;
            flush_e_o  = 1'b1;
            if (BUBBLES != 2'd0) begin
                state_d = ST_REDIRECT;
                bcnt_d  = BUBBLES;
            end
        end else if (luh) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end
    end

    always_comb begin
        redirect_pc_o = redirect_o ? ex_br_target_i : '0;
        stall_cnt_d   = stall_cnt_q;
        redir_cnt_d   = redir_cnt_q;
        if (stall_f_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect_o && (redir_cnt_q != '1)) begin
            redir_cnt_d = redir_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            bcnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign redir_cnt_o = redir_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus, one with
// REDIRECT_BUBBLES=1/CNT_WIDTH=16 and one with REDIRECT_BUBBLES=2/CNT_WIDTH=4.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken, mem_busy;
    logic [31:0] ex_br_target;

    logic        sf1, sd1, se1, fd1, fe1, rd1;
    logic [31:0] pc1;
    logic [15:0] scnt1, rcnt1;
    logic        sf2, sd2, se2, fd2, fe2, rd2;
    logic [31:0] pc2;
    logic [3:0]  scnt2, rcnt2;
    logic [5:0]  ctl1, ctl2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Control vector order: {stall_f, stall_d, stall_e, flush_d, flush_e, redirect}
    assign ctl1 = {sf1, sd1, se1, fd1, fe1, rd1};
    assign ctl2 = {sf2, sd2, se2, fd2, fe2, rd2};

    hazard_ctrl #(.AWIDTH(32), .REDIRECT_BUBBLES(1), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load),
        .ex_br_taken_i(ex_br_taken), .ex_br_target_i(ex_br_target),
        .mem_busy_i(mem_busy),
        .stall_f_o(sf1), .stall_d_o(sd1), .stall_e_o(se1),
        .flush_d_o(fd1), .flush_e_o(fe1),
        .redirect_o(rd1), .redirect_pc_o(pc1),
        .stall_cnt_o(scnt1), .redir_cnt_o(rcnt1)
    );

    hazard_ctrl #(.AWIDTH(32), .REDIRECT_BUBBLES(2), .CNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load),
        .ex_br_taken_i(ex_br_taken), .ex_br_target_i(ex_br_target),
        .mem_busy_i(mem_busy),
        .stall_f_o(sf2), .stall_d_o(sd2), .stall_e_o(se2),
        .flush_d_o(fd2), .flush_e_o(fe2),
        .redirect_o(rd2), .redirect_pc_o(pc2),
        .stall_cnt_o(scnt2), .redir_cnt_o(rcnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
        ex_br_taken = 1'b0; mem_busy = 1'b0; ex_br_target = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_luh_rs1(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
        ex_is_load = 1'b1; ex_rd = rd; id_rs1 = rs1; id_uses_rs1 = use1;
    endtask

    initial begin
        // Reset dominates a taken branch in the same cycle
        idle_inputs();
        rst = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'hDEAD_BEE0; mem_busy = 1'b0;
        #1;
        chk("rst_ctl1", 32'(ctl1), 32'h0);
        chk("rst_pc1", pc1, 32'h0);
        next_cycle();
        idle_inputs();
        #1;
        chk("post_rst_scnt1", 32'(scnt1), 32'h0);
        chk("post_rst_rcnt1", 32'(rcnt1), 32'h0);
        chk("idle_ctl1", 32'(ctl1), 32'h0);

        // Load-use hazard on rs1
        set_luh_rs1(5'd5, 5'd5, 1'b1);
        #1;
        chk("luh_ctl1", 32'(ctl1), 32'(6'b110010));
        chk("luh_ctl2", 32'(ctl2), 32'(6'b110010));
        next_cycle();
        idle_inputs();
        #1;
        chk("luh_scnt1", 32'(scnt1), 32'd1);
        chk("luh_clear_ctl1", 32'(ctl1), 32'h0);
        set_luh_rs1(5'd0, 5'd0, 1'b1);
        #1;
        chk("luh_rd0_ctl1", 32'(ctl1), 32'h0);
        set_luh_rs1(5'd5, 5'd5, 1'b0);
        #1;
        chk("luh_nouse_ctl1", 32'(ctl1), 32'h0);
        idle_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        #1;
        chk("luh_rs2_ctl1", 32'(ctl1), 32'(6'b110010));
        next_cycle();

        // Taken branch: redirect, then bubbles (1 for dut1, 2 for dut2)
        do_reset();
        ex_br_taken = 1'b1; ex_br_target = 32'h0100_0040;
        set_luh_rs1(5'd3, 5'd3, 1'b1);
        #1;
        chk("br_ctl1", 32'(ctl1), 32'(6'b000111));
        chk("br_pc1", pc1, 32'h0100_0040);
        next_cycle();
        idle_inputs();
        ex_br_target = 32'h1234_5678;
        #1;
        chk("br_n1_ctl1", 32'(ctl1), 32'(6'b000100));
        chk("br_n1_pc1", pc1, 32'h0);
        chk("br_n1_ctl2", 32'(ctl2), 32'(6'b000100));
        chk("br_n1_rcnt1", 32'(rcnt1), 32'd1);
        next_cycle();
        set_luh_rs1(5'd9, 5'd9, 1'b1);
        #1;
        chk("br_n2_ctl1", 32'(ctl1), 32'(6'b110010));
        chk("br_n2_ctl2", 32'(ctl2), 32'(6'b000100));
        next_cycle();
        idle_inputs();
        #1;
        chk("br_n3_ctl2", 32'(ctl2), 32'h0);
        chk("br_n3_rcnt1", 32'(rcnt1), 32'd1);
        chk("br_n3_scnt1", 32'(scnt1), 32'd1);

        // Branch deferred across three busy cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h0000_0ABC;
            #1;
            chk("busy_br_ctl1", 32'(ctl1), 32'(6'b111000));
            chk("busy_br_pc1", pc1, 32'h0);
            next_cycle();
        end
        mem_busy = 1'b0;
        #1;
        chk("deferred_br_ctl1", 32'(ctl1), 32'(6'b000111));
        chk("deferred_br_pc1", pc1, 32'h0000_0ABC);
        next_cycle();
        idle_inputs();
        #1;
        chk("deferred_bubble_ctl1", 32'(ctl1), 32'(6'b000100));
        chk("deferred_scnt1", 32'(scnt1), 32'd3);
        chk("deferred_rcnt1", 32'(rcnt1), 32'd1);
        next_cycle();
        chk("deferred_run_ctl1", 32'(ctl1), 32'h0);

        // Busy during REDIRECT freezes bubble count (dut2); busy+luh gives no flush_e (dut1)
        do_reset();
        ex_br_taken = 1'b1; ex_br_target = 32'h0000_2000;
        next_cycle();
        idle_inputs();
        #1;
        chk("rb2_b1_ctl2", 32'(ctl2), 32'(6'b000100));
        next_cycle();
        mem_busy = 1'b1;
        set_luh_rs1(5'd4, 5'd4, 1'b1);
        #1;
        chk("rb2_busy_ctl2", 32'(ctl2), 32'(6'b111000));
        chk("busy_luh_ctl1", 32'(ctl1), 32'(6'b111000));
        next_cycle();
        mem_busy = 1'b0;
        #1;
        chk("rb2_b2_ctl2", 32'(ctl2), 32'(6'b000100));
        chk("luh_after_busy_ctl1", 32'(ctl1), 32'(6'b110010));
        next_cycle();
        idle_inputs();
        #1;
        chk("rb2_run_ctl2", 32'(ctl2), 32'h0);

        // Stall counter saturation on the 4-bit instance
        do_reset();
        mem_busy = 1'b1;
        repeat (20) next_cycle();
        mem_busy = 1'b0;
        #1;
        chk("sat_scnt2", 32'(scnt2), 32'h0000_000F);
        chk("sat_scnt1", 32'(scnt1), 32'd20);

        // Reset while dut2 sits in REDIRECT with bcnt=2
        do_reset();
        ex_br_taken = 1'b1; ex_br_target = 32'h0000_4000;
        next_cycle();
        idle_inputs();
        rst = 1'b1; mem_busy = 1'b1; ex_br_taken = 1'b1;
        #1;
        chk("rst_redir_ctl2", 32'(ctl2), 32'h0);
        chk("rst_redir_pc2", pc2, 32'h0);
        next_cycle();
        idle_inputs();
        #1;
        chk("post_rst_redir_ctl2", 32'(ctl2), 32'h0);
        chk("post_rst_redir_rcnt2", 32'(rcnt2), 32'h0);
        chk("post_rst_redir_scnt2", 32'(scnt2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I core. It sequences the fetch, decode and execute pipeline registers by generating stall, flush and PC-redirect controls. The controls cover load-use hazards, taken branches/jumps resolved in execute, and multi-cycle data-memory waits. The block also keeps saturating performance counters for stalls and redirects.

## Interface

Parameters:
- AWIDTH, 32, PC/address width
- REDIRECT_BUBBLES, 1, extra decode-flush cycles after a redirect (legal 0..3), covering instruction-memory read latency
- CNT_WIDTH, 16, width of each performance counter

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- id_rs1_i  in  5  rs1 of the instruction in decode
- id_rs2_i  in  5  rs2 of the instruction in decode
- id_uses_rs1_i  in  1  decode instruction reads rs1
- id_uses_rs2_i  in  1  decode instruction reads rs2
- ex_rd_i  in  5  rd of the instruction in execute
- ex_is_load_i  in  1  execute instruction is a load
- ex_br_taken_i  in  1  execute instruction is a taken branch or jump
- ex_br_target_i  in  AWIDTH  its target PC
- mem_busy_i  in  1  data-memory access in MEM not yet complete
- stall_f_o  out  1  hold PC / fetch register
- stall_d_o  out  1  hold decode pipeline register
- stall_e_o  out  1  hold execute pipeline register
- flush_d_o  out  1  load NOP (0x00000013) into decode register
- flush_e_o  out  1  load NOP into execute register (bubble)
- redirect_o  out  1  PC mux selects redirect_pc_o next edge
- redirect_pc_o  out  AWIDTH  redirect target
- stall_cnt_o  out  CNT_WIDTH  cycles with stall_f_o=1, saturating
- redir_cnt_o  out  CNT_WIDTH  redirect_o pulses, saturating

## Operation

- luh = ex_is_load_i & (ex_rd_i != 0) & ((id_uses_rs1_i & id_rs1_i == ex_rd_i) | (id_uses_rs2_i & id_rs2_i == ex_rd_i)).
- States: RUN, REDIRECT. A bubble counter bcnt (2 bits) is associated with REDIRECT.
- Per-cycle priority: rst > mem_busy_i > ex_br_taken_i > luh.
- mem_busy_i=1, in any state:
  - stall_f/d/e = 1; all flushes and redirect = 0.
  - State and bcnt hold.
  - A branch in execute stays frozen, so its redirect is deferred until the first non-busy cycle.
- RUN, ex_br_taken_i=1:
  - redirect_o = 1, redirect_pc_o = ex_br_target_i, flush_d_o = 1, flush_e_o = 1.
  - If REDIRECT_BUBBLES>0, next state is REDIRECT with bcnt = REDIRECT_BUBBLES; otherwise stay in RUN.
- RUN, luh=1 (no branch):
  - stall_f = stall_d = 1, flush_e = 1.
  - Lasts exactly one cycle; luh clears naturally once the load advances.
- REDIRECT, mem_busy_i=0:
  - flush_d_o = 1; all other controls 0. luh and ex_br_taken_i are ignored because execute holds a bubble.
  - bcnt decrements; on the cycle bcnt==1 the next state is RUN.
- Idle (none of the above): all controls 0.
- redirect_pc_o = ex_br_target_i when redirect_o=1, otherwise 0.
- Counters:
  - stall_cnt_o += 1 on each cycle with stall_f_o=1.
  - redir_cnt_o += 1 on each redirect_o=1.
  - Both hold at 2^CNT_WIDTH-1 (no wrap).

## Timing

- All control outputs are combinational from current state plus inputs, with 0 latency in the same cycle. The only registered values are state, bcnt and the counters.
- rst=1 forces every control output to 0 in that cycle. Next state is RUN, bcnt=0, both counters 0.
- Reset mid-REDIRECT or mid-wait abandons the pending bubbles; the first post-reset cycle is RUN.
- redirect_o is a single-cycle pulse per taken branch, including a branch deferred across any number of mem_busy_i cycles.
- Simultaneous luh and ex_br_taken_i: branch wins, no stall; flush_d_o squashes the hazarded instruction.
- Simultaneous mem_busy_i and luh: stall only, flush_e_o=0. luh is re-evaluated after busy clears.

## Test plan

- Load-use hazard:
  - Stimulus: ex_is_load_i=1, ex_rd_i=5, id_rs1_i=5, id_uses_rs1_i=1 for one cycle.
  - Response: stall_f=stall_d=flush_e=1 that cycle, stall_cnt_o=1. With ex_rd_i=0 or id_uses_rs1_i=0, all controls stay 0.
- Taken branch, REDIRECT_BUBBLES=1:
  - Stimulus: ex_br_taken_i=1, target 0x01000040.
  - Response: cycle N has redirect_o=1, pc=0x01000040, flush_d=flush_e=1. Cycle N+1 has only flush_d_o=1. Cycle N+2 is back in RUN. redir_cnt_o=1.
- Branch during memory wait:
  - Stimulus: mem_busy_i=1 for 3 cycles while ex_br_taken_i=1.
  - Response: 3 cycles of stall_f/d/e=1 with redirect_o=0, then a single redirect pulse. stall_cnt_o=3, redir_cnt_o=1.
- mem_busy_i during REDIRECT with REDIRECT_BUBBLES=2:
  - Response: bubble count freezes during the busy cycle and resumes after; exactly 2 flush_d-only cycles in total.
- Counter saturation, CNT_WIDTH=4:
  - Stimulus: hold mem_busy_i=1 for 20 cycles.
  - Response: stall_cnt_o stops at 0xF.
- Reset in REDIRECT:
  - Stimulus: assert rst for 1 cycle while bcnt=2.
  - Response: all outputs 0 that cycle; the next cycle is RUN with no flush_d_o and counters 0.
